// File: rtl/cache_arbiter.sv
// Arbiter sharing one physical-memory port between I-cache and D-cache line requests.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed D-side priority.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  // state  | meaning
  // IDLE   | no transaction; arbitrate pending requests
  // I_BUSY | I-side line access in flight on pmem
  // D_BUSY | D-side line access in flight on pmem
  // DONE   | one-cycle resp to the granted side
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic                gnt_d_q, gnt_d_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   irdata_q, irdata_d;
  logic [LINE_W-1:0]   drdata_q, drdata_d;
  logic                i_req, d_req, pick_d, busy;

  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;

  // gnt_d_q keeps the side of the most recent grant; round robin uses it as last-grant.
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  assign pick_d = d_req & (~i_req | ~gnt_d_q);
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d_d  = gnt_d_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_d_d = pick_d;
          state_d = pick_d ? D_BUSY : I_BUSY;
          addr_d  = pick_d ? dcache_address : icache_address;
          op_wr_d = pick_d & dcache_write;
          if (pick_d) wdata_d = dcache_wdata;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          state_d = DONE;
          if (!op_wr_q) begin
            if (state_q == I_BUSY) irdata_d = pmem_rdata;
            else                   drdata_d = pmem_rdata;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_d_q  <= 1'b0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_d_q  <= gnt_d_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  assign busy         = (state_q == I_BUSY) || (state_q == D_BUSY);
  assign pmem_read    = busy & ~op_wr_q;
  assign pmem_write   = busy & op_wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign icache_resp  = (state_q == DONE) & ~gnt_d_q;
  assign dcache_resp  = (state_q == DONE) & gnt_d_q;
  assign icache_rdata = irdata_q;
  assign dcache_rdata = drdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: random request rounds against a transaction-level model.
// Honours CACHE_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_read;
  logic [AW-1:0] icache_address;
  logic [LW-1:0] icache_rdata;
  logic          icache_resp;
  logic          dcache_read, dcache_write;
  logic [AW-1:0] dcache_address;
  logic [LW-1:0] dcache_wdata, dcache_rdata;
  logic          dcache_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [AW-1:0] addr; logic [LW-1:0] wdata; } pm_t;
  typedef struct { bit side_d; logic [LW-1:0] rdata; } rs_t;

  pm_t exp_pmem[$];
  rs_t exp_resp[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  bit            last_d = 1'b0;
  logic [LW-1:0] model_irdata = '0;
  logic [LW-1:0] model_drdata = '0;

  bit mem_hold = 1'b0;
  int spur_cnt = 0;

  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_C3C3}};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event missing expected event seen", name);
  endtask

  // memory model: random latency, data derived from the address
  initial begin : responder
    bit busy_seen;
    int wait_left;
    int spur_done;
    busy_seen = 0; wait_left = 0; spur_done = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (spur_cnt != spur_done) begin
        spur_done++;
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'hDEAD_BEEF}};
      end else if (rst && !mem_hold && (pmem_read || pmem_write)) begin
        if (!busy_seen) begin
          busy_seen = 1;
          wait_left = $urandom_range(0, 5);
        end
        if (wait_left == 0) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem_line(pmem_address);
          busy_seen  = 0;
        end else begin
          wait_left--;
        end
      end else begin
        busy_seen = 0;
      end
    end
  end

  initial begin : monitor
    pm_t cur;
    rs_t r;
    bit  prev_acc;
    bit  acc;
    prev_acc = 0;
    cur = '{wr: 1'b0, addr: '0, wdata: '0};
    forever begin
      @(negedge clk);
      acc = pmem_read || pmem_write;
      chk("pmem_rd_wr_excl", LW'(pmem_read & pmem_write), '0);
      if (acc && !prev_acc) begin
        if (exp_pmem.size() == 0) fail_now("unexpected_pmem_access");
        else cur = exp_pmem.pop_front();
      end
      if (acc) begin
        chk("pmem_write", LW'(pmem_write), LW'(cur.wr));
        chk("pmem_address", LW'(pmem_address), LW'(cur.addr));
        if (cur.wr) chk("pmem_wdata", pmem_wdata, cur.wdata);
      end
      prev_acc = acc;
      chk("resp_excl", LW'(icache_resp & dcache_resp), '0);
      if (icache_resp || dcache_resp) begin
        if (exp_resp.size() == 0) fail_now("unexpected_resp");
        else begin
          r = exp_resp.pop_front();
          chk("resp_side", LW'(dcache_resp), LW'(r.side_d));
          chk("resp_rdata", dcache_resp ? dcache_rdata : icache_rdata, r.rdata);
        end
      end
    end
  end

  // model one transaction: push the expected pmem access and resp
  task automatic model_txn(input bit side_d, input bit wr, input logic [AW-1:0] a,
                           input logic [LW-1:0] wd);
    rs_t r;
    exp_pmem.push_back('{wr: wr, addr: a, wdata: wd});
    if (!wr) begin
      if (side_d) model_drdata = mem_line(a);
      else        model_irdata = mem_line(a);
    end
    r.side_d = side_d;
    r.rdata  = side_d ? model_drdata : model_irdata;
    exp_resp.push_back(r);
    last_d = side_d;
  endtask

  task automatic run_round(input int kind);
    bit use_i, use_d, d_wr, d_first, i_pend, d_pend;
    logic [AW-1:0] ai, ad;
    logic [LW-1:0] wd;
    use_i = (kind != 1);
    use_d = (kind != 0);
    d_wr  = $urandom_range(0, 1) == 1;
    ai = $urandom() & 32'hFFFF_FFE0;
    ad = $urandom() & 32'hFFFF_FFE0;
    wd = rand_line();
    if (use_i && use_d) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      d_first = !last_d;
`else
      d_first = 1;
`endif
    end else begin
      d_first = use_d;
    end
    @(negedge clk);
    if (d_first) begin
      model_txn(1, d_wr, ad, wd);
      if (use_i) model_txn(0, 0, ai, '0);
    end else begin
      model_txn(0, 0, ai, '0);
      if (use_d) model_txn(1, d_wr, ad, wd);
    end
    icache_read    = use_i;
    icache_address = ai;
    dcache_read    = use_d && ($urandom_range(0, 1) == 1 || !d_wr);
    dcache_write   = use_d && d_wr;
    dcache_address = ad;
    dcache_wdata   = wd;
    @(negedge clk);
    // the first-granted side has been latched; its live inputs must no longer matter
    if (d_first) begin
      dcache_address = $urandom();
      dcache_wdata   = rand_line();
    end else begin
      icache_address = $urandom();
    end
    i_pend = use_i;
    d_pend = use_d;
    for (int k = 0; k < 100 && (i_pend || d_pend); k++) begin
      @(negedge clk);
      if (i_pend && icache_resp) begin i_pend = 0; icache_read = 1'b0; end
      if (d_pend && dcache_resp) begin
        d_pend = 0; dcache_read = 1'b0; dcache_write = 1'b0;
      end
    end
    if (i_pend || d_pend) begin
      fail_now("resp_timeout");
      icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
      exp_pmem.delete();
      exp_resp.delete();
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic reset_mid_txn();
    logic [AW-1:0] a;
    bit got;
    a = $urandom() & 32'hFFFF_FFE0;
    @(negedge clk);
    mem_hold = 1;
    exp_pmem.push_back('{wr: 1'b0, addr: a, wdata: '0});
    icache_read = 1'b1;
    icache_address = a;
    repeat (3) @(negedge clk);
    chk("busy_pmem_read", LW'(pmem_read), LW'(1));
    rst = 1'b0;
    #1;
    chk("rst_pmem_read", LW'(pmem_read), '0);
    chk("rst_icache_resp", LW'(icache_resp), '0);
    chk("rst_icache_rdata", icache_rdata, '0);
    last_d = 0;
    model_irdata = '0;
    model_drdata = '0;
    @(negedge clk);
    rst = 1'b1;
    mem_hold = 0;
    model_txn(0, 0, a, '0);
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (icache_resp) got = 1;
    end
    if (!got) begin
      fail_now("rst_retry_timeout");
      exp_pmem.delete();
      exp_resp.delete();
    end
    icache_read = 1'b0;
  endtask

  initial begin : main
    logic [LW-1:0] hold_i, hold_d;
    rst = 1'b0;
    icache_read = 1'b0; icache_address = '0;
    dcache_read = 1'b0; dcache_write = 1'b0;
    dcache_address = '0; dcache_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_pmem_read", LW'(pmem_read), '0);
    chk("rst_pmem_write", LW'(pmem_write), '0);
    chk("rst_icache_resp", LW'(icache_resp), '0);
    chk("rst_dcache_resp", LW'(dcache_resp), '0);
    chk("rst_pmem_address", LW'(pmem_address), '0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_icache_rdata", icache_rdata, '0);
    chk("rst_dcache_rdata", dcache_rdata, '0);
    rst = 1'b1;
    @(negedge clk);

    hold_i = icache_rdata;
    hold_d = dcache_rdata;
    spur_cnt++;
    repeat (4) @(negedge clk);
    chk("spur_pmem_read", LW'(pmem_read | pmem_write), '0);
    chk("spur_icache_rdata", icache_rdata, hold_i);
    chk("spur_dcache_rdata", dcache_rdata, hold_d);

    for (int n = 0; n < 40; n++) run_round($urandom_range(0, 2));
    reset_mid_txn();
    for (int n = 0; n < 30; n++) run_round($urandom_range(0, 2));

    hold_i = model_irdata;
    hold_d = model_drdata;
    spur_cnt++;
    repeat (5) @(negedge clk);
    chk("idle_icache_rdata_hold", icache_rdata, hold_i);
    chk("idle_dcache_rdata_hold", dcache_rdata, hold_d);
    chk("exp_pmem_drained", LW'(exp_pmem.size()), '0);
    chk("exp_resp_drained", LW'(exp_resp.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, physical byte-address width.
REQ-002 SHALL have parameter LINE_W, default 256, cache-line data width in bits.
REQ-003 SHALL use one clock; reset is asynchronous and active-low; ports: clk  in  1  clock; rst  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports icache_read  in  1  I-side line read request; icache_address  in  ADDR_W  I-side line address; icache_rdata  out  LINE_W  I-side returned line; icache_resp  out  1  I-side completion pulse.
REQ-005 SHALL have ports dcache_read  in  1; dcache_write  in  1; dcache_address  in  ADDR_W; dcache_wdata  in  LINE_W; dcache_rdata  out  LINE_W; dcache_resp  out  1; all D-side equivalents, with write-back data on dcache_wdata.
REQ-006 SHALL have ports pmem_read  out  1; pmem_write  out  1; pmem_address  out  ADDR_W; pmem_wdata  out  LINE_W; pmem_rdata  in  LINE_W; pmem_resp  in  1; the single shared physical-memory port.

Function
REQ-007 SHALL implement FSM states IDLE, I_BUSY, D_BUSY, DONE.
REQ-008 IDLE: when any request is pending, SHALL grant per REQ-015 and enter I_BUSY or D_BUSY on the next edge, latching address, wdata and op (read/write) into internal registers.
REQ-009 I_BUSY/D_BUSY: SHALL drive pmem_read/pmem_write, pmem_address and pmem_wdata from the latched values only, never from live requester inputs.
REQ-010 Busy state: on pmem_resp=1 SHALL latch pmem_rdata for reads, drop pmem_read/pmem_write, and enter DONE on the next edge.
REQ-011 DONE: SHALL assert exactly one resp (granted side) for exactly one cycle, with rdata valid that cycle, then return to IDLE.
REQ-012 Grant-to-pmem latency SHALL be 1 cycle; pmem_resp-to-requester-resp latency SHALL be 1 cycle; minimum transaction is 3 cycles (IDLE, BUSY, DONE).
REQ-013 A requester SHALL hold its request until its resp; requests seen in DONE SHALL NOT be granted until IDLE, so a requester dropping its request after resp is never re-serviced.
REQ-014 Request deassertion or input change during busy SHALL NOT alter the in-flight transaction.
REQ-015 Two requesters pending in IDLE in the same cycle SHALL be resolved per REQ-021/REQ-022; a single pending requester SHALL always be granted.
REQ-016 dcache_read and dcache_write both high SHALL be treated as write.
REQ-017 pmem_resp in IDLE or DONE SHALL be ignored.
REQ-018 icache_rdata/dcache_rdata SHALL hold the last latched line between transactions; the non-granted resp SHALL stay 0.

Reset
REQ-019 On rst=0, SHALL asynchronously enter IDLE; pmem_read, pmem_write, icache_resp and dcache_resp are 0; pmem_address, pmem_wdata, rdata registers are 0; last-grant register is I-side.
REQ-020 Reset mid-transaction SHALL abandon it with no resp issued; after release, requests still asserted are arbitrated afresh.

Configuration
REQ-021 With macro CACHE_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the side not granted last (per last-grant register, updated at each grant).
REQ-022 Without CACHE_ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always be granted to the D-side (fixed priority); the last-grant register is absent.

Verification
REQ-023 Single I read: icache_read=1, addr 0x0000_0040, pmem_resp after 5 cycles with rdata 0xA5..A5 -> pmem_read high 5 cycles with address 0x40, icache_resp single pulse with rdata 0xA5..A5, dcache_resp stays 0.
REQ-024 Simultaneous I read 0x100 and D write 0x200 (fixed priority) -> D write issued first with pmem_wdata = dcache_wdata, then I read 0x100; each resp exactly one pulse.
REQ-025 With CACHE_ARB_ROUND_ROBIN_EN, both sides continuously requesting for 4 transactions -> grants alternate D, I, D, I (last-grant reset I-side, so D first).
REQ-026 Change dcache_address from 0x300 to 0x400 during D_BUSY -> pmem_address stays 0x300 until pmem_resp.
REQ-027 Assert rst=0 two cycles into I_BUSY -> pmem_read drops immediately, no icache_resp; after release with icache_read still high, a new read for the same address is issued.
REQ-028 pmem_resp pulsed in IDLE with no requests -> no resp, state stays IDLE.
